// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the inverse cipher: FSM states, key schedule
// constants and GF(2^8) / block transforms.
package aes_pkg;
  localparam int NR = 10;
  localparam int NK = 4;

  typedef logic [127:0] block_t;
  typedef enum logic [2:0] {IDLE, KEXP, INIT, ROUND, FINAL} state_e;

  localparam logic [7:0] RCON [NR] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [7:0] mul09(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] mul0b(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] mul0d(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] mul0e(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

  // Multiplicative inverse as a^254 (= a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // Byte b = 4*col + row sits at bits [127-8*b -: 8].
  function automatic block_t inv_shift_rows(input block_t s);
    block_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic block_t inv_mix_columns(input block_t s);
    block_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
      o[119-32*c -: 8] = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
      o[111-32*c -: 8] = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
      o[103-32*c -: 8] = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
    end
    return o;
  endfunction
endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box, one per state byte in the InvSubBytes layer.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  assign out_byte = sbox_inv(in_byte);
endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, used by the key schedule's SubWord.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  assign out_byte = sbox_fwd(in_byte);
endmodule

// File: rtl/aes_inv_cipher_top.sv
// Iterative AES-128 inverse cipher: full key schedule stored up front, then one
// inverse round per cycle walking the round keys from rk[10] down to rk[0].
module aes_inv_cipher_top
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic         done,
  output logic [127:0] text_out,
  output logic [3:0]   dcnt
);
  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  block_t     blk_q, blk_d;
  block_t     text_out_q, text_out_d;
  logic       done_q, done_d;
  block_t     rk_q [NR+1];
  block_t     rk_d [NR+1];

  logic [3:0]  kidx;
  block_t      rk_prev, rk_new, rk_sel, shifted, subbed;
  logic [31:0] rot_w, sub_w, tmp_w, w0, w1, w2, w3;

  // cnt_q doubles as key-schedule index (1..10) and round-key index (10..0).
  assign kidx    = cnt_q - 4'd1;
  assign rk_prev = rk_q[kidx];
  assign rk_sel  = rk_q[cnt_q];
  assign rot_w   = {rk_prev[23:0], rk_prev[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ksbox
      aes_sbox u_sbox (.in_byte(rot_w[31-8*gi -: 8]), .out_byte(sub_w[31-8*gi -: 8]));
    end
    for (gi = 0; gi < 16; gi++) begin : g_isbox
      aes_inv_sbox u_isbox (.in_byte(shifted[127-8*gi -: 8]), .out_byte(subbed[127-8*gi -: 8]));
    end
  endgenerate

  always_comb begin
    tmp_w   = sub_w ^ {RCON[kidx], 24'h0};
    w0      = rk_prev[127:96] ^ tmp_w;
    w1      = rk_prev[95:64] ^ w0;
    w2      = rk_prev[63:32] ^ w1;
    w3      = rk_prev[31:0] ^ w2;
    rk_new  = {w0, w1, w2, w3};
    shifted = inv_shift_rows(blk_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ld) state_d = KEXP;
      KEXP:    if (cnt_q == 4'd10) state_d = INIT;
      INIT:    state_d = ROUND;
      ROUND:   if (cnt_q == 4'd1) state_d = FINAL;
      FINAL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    blk_d      = blk_q;
    text_out_d = text_out_q;
    done_d     = 1'b0;
    rk_d       = rk_q;
    case (state_q)
      IDLE: if (ld) begin
        rk_d[0] = key;
        blk_d   = text_in;
        cnt_d   = 4'd1;
      end
      KEXP: begin
        rk_d[cnt_q] = rk_new;
        if (cnt_q != 4'd10) cnt_d = cnt_q + 4'd1;
      end
      INIT: begin
        blk_d = blk_q ^ rk_sel;
        cnt_d = 4'd9;
      end
      ROUND: begin
        blk_d = inv_mix_columns(subbed ^ rk_sel);
        cnt_d = cnt_q - 4'd1;
      end
      FINAL: begin
        text_out_d = subbed ^ rk_sel;
        done_d     = 1'b1;
        cnt_d      = 4'd0;
      end
      default: cnt_d = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q      <= '0;
      blk_q      <= '0;
      text_out_q <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
    end else begin
      cnt_q      <= cnt_d;
      blk_q      <= blk_d;
      text_out_q <= text_out_d;
      done_q     <= done_d;
      rk_q       <= rk_d;
    end
  end

  always_comb begin
    done     = done_q;
    text_out = text_out_q;
    dcnt     = (state_q == ROUND) ? cnt_q : 4'd0;
  end
endmodule

// File: tb/tb_aes_inv_cipher_top.sv
// Directed bench for aes_inv_cipher_top: FIPS-197 vectors, ignored ld, abort by
// reset and back-to-back operation, with a done-driven result scoreboard.
module tb_aes_inv_cipher_top;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ld = 1'b0;
  logic [127:0] key = '0;
  logic [127:0] text_in = '0;
  logic         done;
  logic [127:0] text_out;
  logic [3:0]   dcnt;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] ALT_CT = 128'hdeadbeef0123456789abcdeffedcba98;

  typedef struct {
    logic [127:0] pt;
    int           acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_cipher_top dut (
    .clk(clk), .rst(rst), .ld(ld), .key(key), .text_in(text_in),
    .done(done), .text_out(text_out), .dcnt(dcnt)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // k = negedges since the accepting edge: 11 zero cycles, then 9..1, then 0.
  function automatic logic [3:0] exp_dcnt(input int k);
    return (k >= 11 && k <= 19) ? 4'(20 - k) : 4'd0;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("done_unexpected", 128'(done), 128'd0);
      end else begin
        e = sb_q.pop_front();
        check("result", text_out, e.pt);
        check("latency", 128'(cyc), 128'(e.acc_cyc + 21));
        $display("txn done cyc=%0d text_out=%h", cyc, text_out);
      end
    end
  end

  initial begin
    rst = 1'b0;
    ld  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_done", 128'(done), 128'd0);
    check("rst_text_out", text_out, 128'd0);
    check("rst_dcnt", 128'(dcnt), 128'd0);

    // C.1 run with a second ld (different data) on the 5th busy cycle
    rst = 1'b1; key = C1_KEY; text_in = C1_CT; ld = 1'b1;
    sb_q.push_back('{C1_PT, cyc + 1});
    $display("txn ld C.1 cyc=%0d", cyc + 1);
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk);
      ld = 1'b0; key = rnd128(); text_in = rnd128();
      if (k == 4) begin ld = 1'b1; key = B_KEY; text_in = ALT_CT; end
      check("dcnt_c1", 128'(dcnt), 128'(exp_dcnt(k)));
      if (k <= 20) check("text_out_pre_c1", text_out, 128'd0);
    end

    // Back-to-back: App.B loaded on the done cycle of the C.1 run
    ld = 1'b1; key = B_KEY; text_in = B_CT;
    sb_q.push_back('{B_PT, cyc + 1});
    $display("txn ld App.B back-to-back cyc=%0d", cyc + 1);
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk);
      ld = 1'b0; key = rnd128(); text_in = rnd128();
      if (k == 1) check("single_done_c1", 128'(done_cnt), 128'd1);
      check("dcnt_b2b", 128'(dcnt), 128'(exp_dcnt(k)));
      if (k <= 20) check("text_out_hold_c1", text_out, C1_PT);
    end

    // Abort by reset during the dcnt=5 round, with ld asserted alongside reset
    @(negedge clk);
    ld = 1'b1; key = C1_KEY; text_in = C1_CT;
    $display("txn ld C.1 to be aborted cyc=%0d", cyc + 1);
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      ld = 1'b0;
      check("dcnt_abort", 128'(dcnt), 128'(exp_dcnt(k)));
    end
    rst = 1'b0; ld = 1'b1; key = B_KEY; text_in = B_CT;
    @(negedge clk);
    check("abort_done", 128'(done), 128'd0);
    check("abort_text_out", text_out, 128'd0);
    check("abort_dcnt", 128'(dcnt), 128'd0);
    rst = 1'b1; ld = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      check("idle_dcnt", 128'(dcnt), 128'd0);
      check("idle_text_out", text_out, 128'd0);
    end

    // Fresh App.B run after the abort
    ld = 1'b1; key = B_KEY; text_in = B_CT;
    sb_q.push_back('{B_PT, cyc + 1});
    $display("txn ld App.B after reset cyc=%0d", cyc + 1);
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk);
      ld = 1'b0; key = rnd128(); text_in = rnd128();
      check("dcnt_b", 128'(dcnt), 128'(exp_dcnt(k)));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 128'(sb_q.size()), 128'd0);
    check("done_total", 128'(done_cnt), 128'd3);
    check("final_text_out", text_out, B_PT);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
